// File: rtl/idct_sched_pkg.sv
// Shared types and widths for the IDCT block scheduler.
package idct_sched_pkg;

    localparam int COEF_BLK_W = 1024;
    localparam int PIX_BLK_W  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/idct_out_fifo.sv
// Result FIFO holding {tag, pixel block}; head is zero whenever the FIFO is empty.
module idct_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 514,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign valid   = (count != '0);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/idct_block_scheduler.sv
// Round-robin scheduler sharing one two-pass IDCT engine between NUM_REQ producers.
// state | meaning
// IDLE  | arbitrate; grant only when a FIFO slot is free
// ISSUE | one-cycle eng_s_valid pulse with the latched block
// WAIT  | block in flight; wait for eng_m_valid or timeout
module idct_block_scheduler
    import idct_sched_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TAG_W       = 2,
    parameter int OUT_DEPTH   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*COEF_BLK_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          eng_s_valid,
    output logic [COEF_BLK_W-1:0]         eng_data_in,
    input  logic                          eng_m_valid,
    input  logic [PIX_BLK_W-1:0]          eng_data_out,
    output logic                          out_valid,
    output logic [PIX_BLK_W-1:0]          out_data,
    output logic [TAG_W-1:0]              out_tag,
    input  logic                          out_ready,
    output logic                          err_timeout
);

    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int FIFO_W = PIX_BLK_W + TAG_W;

    sched_state_t            state;
    logic [COEF_BLK_W-1:0]   issue_reg;
    logic [TAG_W-1:0]        tag_reg;
    logic [TAG_W-1:0]        last_grant;
    logic [TO_W-1:0]         to_cnt;
    logic [CNT_W-1:0]        fifo_count;
    logic [FIFO_W-1:0]       fifo_head;
    logic [TAG_W-1:0]        winner;
    logic [COEF_BLK_W-1:0]   winner_data;
    logic                    grant_ok;
    logic                    push;

    // First valid index after 'last', wrapping; smallest offset wins.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [TAG_W-1:0]   last);
        logic [TAG_W-1:0]   pick;
        logic [NUM_REQ-1:0] sh;
        int                 idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            sh  = v >> idx;
            if (sh[0]) begin
                pick = TAG_W'(idx);
            end
        end
        return pick;
    endfunction

    assign winner   = rr_pick(req_valid, last_grant);
    assign grant_ok = (state == IDLE) && (|req_valid) && (fifo_count < CNT_W'(OUT_DEPTH));

    always_comb begin
        req_ready = '0;
        if (grant_ok) begin
            req_ready = NUM_REQ'(1) << winner;
        end
    end

    always_comb begin
        winner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == TAG_W'(i)) begin
                winner_data = req_data[COEF_BLK_W*i +: COEF_BLK_W];
            end
        end
    end

    assign eng_s_valid = (state == ISSUE);
    assign eng_data_in = issue_reg;

    // Results arriving outside WAIT are stray or late and never reach the FIFO.
    assign push = (state == WAIT) && eng_m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            issue_reg   <= '0;
            tag_reg     <= '0;
            last_grant  <= TAG_W'(NUM_REQ - 1);
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        issue_reg  <= winner_data;
                        tag_reg    <= winner;
                        last_grant <= winner;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (eng_m_valid) begin
                        to_cnt <= '0;
                        state  <= IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    idct_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (FIFO_W),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_reg, eng_data_out}),
        .pop       (out_valid & out_ready),
        .head      (fifo_head),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign out_data = fifo_head[PIX_BLK_W-1:0];
    assign out_tag  = fifo_head[PIX_BLK_W +: TAG_W];

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Directed bench for idct_block_scheduler with a fixed-latency engine model (L=20).
module tb_idct_block_scheduler;
    import idct_sched_pkg::*;

    localparam int NR = 3;
    localparam int TW = 2;
    localparam int L  = 20;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NR-1:0]            req_valid;
    logic [NR*COEF_BLK_W-1:0] req_data;
    logic [NR-1:0]            req_ready;
    logic                     eng_s_valid;
    logic [COEF_BLK_W-1:0]    eng_data_in;
    logic                     eng_m_valid;
    logic [PIX_BLK_W-1:0]     eng_data_out;
    logic                     out_valid;
    logic [PIX_BLK_W-1:0]     out_data;
    logic [TW-1:0]            out_tag;
    logic                     out_ready;
    logic                     err_timeout;

    logic [COEF_BLK_W-1:0]    blk [NR];
    logic [L-1:0]             pipe;
    logic [COEF_BLK_W-1:0]    lat;
    logic                     eng_on;
    logic                     force_mv;
    logic [PIX_BLK_W-1:0]     force_data;

    int checks = 0;
    int errors = 0;
    int k, ng, no, grants, issues;

    always #5 clk = ~clk;

    idct_block_scheduler #(
        .NUM_REQ     (NR),
        .TAG_W       (TW),
        .OUT_DEPTH   (2),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .eng_s_valid  (eng_s_valid),
        .eng_data_in  (eng_data_in),
        .eng_m_valid  (eng_m_valid),
        .eng_data_out (eng_data_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_ready    (out_ready),
        .err_timeout  (err_timeout)
    );

    function automatic logic [PIX_BLK_W-1:0] fpix(input logic [COEF_BLK_W-1:0] b);
        return b[PIX_BLK_W-1:0] ^ {16{32'hA5A5_5A5A}};
    endfunction

    // Engine model: result L cycles after the issue pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
            lat  <= '0;
        end else begin
            pipe <= {pipe[L-2:0], eng_s_valid};
            if (eng_s_valid) lat <= eng_data_in;
        end
    end

    assign eng_m_valid  = (pipe[L-1] & eng_on) | force_mv;
    assign eng_data_out = force_mv ? force_data : fpix(lat);
    assign req_data     = {blk[2], blk[1], blk[0]};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int limit, output int n);
        n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) blk[i] = {32{32'hC0DE_0000 | 32'(i)}};
        rst        = 1'b1;
        req_valid  = '0;
        out_ready  = 1'b0;
        eng_on     = 1'b1;
        force_mv   = 1'b0;
        force_data = '0;
        repeat (3) tick();

        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_s_valid", 512'(eng_s_valid), 512'(0));
        chk("rst_data_in", eng_data_in[511:0], 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_data", out_data, 512'(0));
        chk("rst_out_tag", 512'(out_tag), 512'(0));
        chk("rst_err", 512'(err_timeout), 512'(0));
        rst = 1'b0;
        tick();

        // single block, requester 0
        req_valid = 3'b001;
        #1;
        chk("single_grant", 512'(req_ready), 512'(3'b001));
        tick();
        req_valid = '0;
        chk("single_issue", 512'(eng_s_valid), 512'(1));
        chk("single_din_lo", eng_data_in[511:0], blk[0][511:0]);
        chk("single_din_hi", eng_data_in[1023:512], blk[0][1023:512]);
        tick();
        chk("single_pulse_end", 512'(eng_s_valid), 512'(0));
        wait_out(100, k);
        chk("single_latency", 512'(k + 2), 512'(22));
        chk("single_tag", 512'(out_tag), 512'(0));
        chk("single_data", out_data, fpix(blk[0]));
        out_ready = 1'b1;
        tick();
        chk("single_popped", 512'(out_valid), 512'(0));

        // round robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 3'b111;
        #1;
        ng = 0;
        no = 0;
        k  = 0;
        while (k < 400) begin
            if (out_valid) begin
                chk("rr_tag", 512'(out_tag), 512'(no % 3));
                chk("rr_data", out_data, fpix(blk[no % 3]));
                no++;
            end
            if (no == 6) begin
                req_valid = '0;
                break;
            end
            if (|req_ready) begin
                chk("rr_grant", 512'(req_ready), 512'(3'b001 << (ng % 3)));
                ng++;
            end
            tick();
            k++;
        end
        chk("rr_outputs", 512'(no), 512'(6));
        chk("rr_grants", 512'(ng), 512'(6));
        tick();

        // backpressure: two slots, then grants stop
        out_ready = 1'b0;
        req_valid = 3'b111;
        #1;
        grants = 0;
        issues = 0;
        for (int c = 0; c < 80; c++) begin
            if (|req_ready) grants++;
            if (eng_s_valid) issues++;
            tick();
        end
        chk("bp_grants", 512'(grants), 512'(2));
        chk("bp_issues", 512'(issues), 512'(2));
        chk("bp_ready_low", 512'(req_ready), 512'(0));
        chk("bp_head_valid", 512'(out_valid), 512'(1));
        chk("bp_head_tag0", 512'(out_tag), 512'(0));
        out_ready = 1'b1;
        tick();
        chk("bp_head_tag1", 512'(out_tag), 512'(1));
        chk("bp_resume_grant", 512'(req_ready), 512'(3'b100));
        tick();
        req_valid = '0;
        chk("bp_resume_issue", 512'(eng_s_valid), 512'(1));
        chk("bp_drained", 512'(out_valid), 512'(0));
        wait_out(60, k);
        chk("bp_resume_out", 512'(out_valid), 512'(1));
        chk("bp_resume_tag", 512'(out_tag), 512'(2));
        chk("bp_resume_data", out_data, fpix(blk[2]));
        tick();

        // timeout: engine silent
        eng_on = 1'b0;
        req_valid = 3'b001;
        #1;
        chk("to_grant", 512'(req_ready), 512'(3'b001));
        tick();
        req_valid = '0;
        chk("to_issue", 512'(eng_s_valid), 512'(1));
        tick();
        repeat (254) tick();
        chk("to_err_before", 512'(err_timeout), 512'(0));
        tick();
        chk("to_err_set", 512'(err_timeout), 512'(1));
        chk("to_state_idle", 512'(dut.state), 512'(IDLE));
        chk("to_nothing_out", 512'(out_valid), 512'(0));
        eng_on = 1'b1;
        req_valid = 3'b010;
        #1;
        chk("to_next_grant", 512'(req_ready), 512'(3'b010));
        tick();
        req_valid = '0;
        wait_out(60, k);
        chk("to_next_tag", 512'(out_tag), 512'(1));
        chk("to_next_data", out_data, fpix(blk[1]));
        tick();
        force_data = {16{32'hDEAD_BEEF}};
        force_mv = 1'b1;
        tick();
        force_mv = 1'b0;
        repeat (3) tick();
        chk("stray_dropped", 512'(out_valid), 512'(0));
        chk("err_sticky", 512'(err_timeout), 512'(1));

        // reset mid-WAIT with one block buffered
        out_ready = 1'b0;
        req_valid = 3'b001;
        #1;
        tick();
        req_valid = '0;
        wait_out(60, k);
        chk("mid_buffered", 512'(out_valid), 512'(1));
        req_valid = 3'b010;
        #1;
        tick();
        req_valid = '0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", 512'(out_valid), 512'(0));
        chk("mid_out_data", out_data, 512'(0));
        chk("mid_out_tag", 512'(out_tag), 512'(0));
        chk("mid_s_valid", 512'(eng_s_valid), 512'(0));
        chk("mid_data_in", eng_data_in[511:0], 512'(0));
        chk("mid_err", 512'(err_timeout), 512'(0));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 3'b001;
        #1;
        chk("post_grant", 512'(req_ready), 512'(3'b001));
        tick();
        req_valid = '0;
        wait_out(60, k);
        chk("post_latency", 512'(k + 1), 512'(22));
        chk("post_tag", 512'(out_tag), 512'(0));
        chk("post_data", out_data, fpix(blk[0]));
        tick();

        // simultaneous push and pop
        out_ready = 1'b0;
        req_valid = 3'b001;
        #1;
        tick();
        req_valid = '0;
        wait_out(60, k);
        req_valid = 3'b010;
        #1;
        tick();
        req_valid = '0;
        k = 0;
        while (!eng_m_valid && k < 60) begin
            tick();
            k++;
        end
        chk("pp_result_seen", 512'(eng_m_valid), 512'(1));
        chk("pp_count_before", 512'(dut.fifo_count), 512'(1));
        chk("pp_head_before", 512'(out_tag), 512'(0));
        out_ready = 1'b1;
        tick();
        chk("pp_count_after", 512'(dut.fifo_count), 512'(1));
        chk("pp_head_tag", 512'(out_tag), 512'(1));
        chk("pp_head_data", out_data, fpix(blk[1]));
        tick();
        chk("pp_empty", 512'(out_valid), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
